risc8_uart_rx: RTL and testbench
================================

// Module: risc8_uart_rx
// PURPOSE
//  Receive half of the SoC serial port; the counterpart of the uart transmitter on serial_tx.
//  Deserialises 8N1 frames from serial_rx into a one-byte holding register.
//  The register is read through the IO map: status at 0x2E, data at 0x2C.
//  Baud divisor is shared with the transmitter (IO 0x2D).
//  Oversampled, 3-sample majority vote, framing and overrun detection.
// PARAMETERS
//  OSR  16  oversample ticks per bit; power of two, >= 8
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-low reset
//  baud_div   in   8  tick every baud_div+1 clocks; bit period = OSR*(baud_div+1) clocks
//  rx_in      in   1  serial line, idle high, asynchronous to clk
//  rx_ack     in   1  1-cycle pulse: CPU read of data register; consumes held byte
//  err_clr    in   1  1-cycle pulse: clears frame_err and overrun
//  rx_data    out  8  held byte; valid while rx_valid=1
//  rx_valid   out  1  holding register full
//  rx_strobe  out  1  1-cycle pulse when a good frame completes (loaded or dropped)
//  frame_err  out  1  sticky: stop bit sampled low
//  overrun    out  1  sticky: good frame arrived while holding register full
//  busy       out  1  FSM not in IDLE
// BEHAVIOUR
//  Reset (reset=0, async):
//   - all outputs 0; FSM=IDLE
//   - both synchroniser flops and the edge-history flop set to 1, so there is no false start.
//  Synchroniser: rx_in -> 2 flops -> rxs.
//  Start detection: falling edge = rxs_prev=1 & rxs=0.
//  Prescaler: counts baud_div down to 0, then reloads and emits a tick.
//  Subsample counter: sub[log2 OSR] counts ticks 0..OSR-1 and wraps at the bit boundary.
//  Both counters are cleared in the start-detect cycle.
//  baud_div changes take effect at the next prescaler reload.
//  Sampling:
//   - rxs is captured on ticks where sub = OSR/2-1, OSR/2 and OSR/2+1.
//   - bit value = majority of the 3 samples; decided on the tick where sub = OSR/2+1.
//  FSM:
//   - IDLE:      falling edge -> START (clear counters, bitcnt=0).
//   - START:     at decision: 1 -> IDLE (glitch, no flags); 0 -> DATA at the next sub wrap.
//   - DATA:      at decision: shift value into shreg[7] (right shift, LSB first), bitcnt++.
//                After the 8th bit -> STOP at the next sub wrap.
//   - STOP:      at decision, if 1 -> complete (see below), -> IDLE.
//                If 0 -> frame_err=1, byte discarded, no rx_strobe, -> WAIT_IDLE.
//   - WAIT_IDLE: stay until rxs=1, then -> IDLE (break/stuck-low safe).
//   - Leaving STOP at mid-bit gives half a bit of slack before the next start edge.
//     Back-to-back frames are received.
//  Completion (good stop bit), same cycle:
//   - rx_strobe=1.
//   - If rx_valid=0, or rx_ack=1 in the same cycle: rx_data<=shreg, rx_valid=1.
//   - Else: overrun=1, new byte dropped, old rx_data kept.
//  rx_ack:
//   - clears rx_valid next cycle, except when it coincides with completion; rx_valid then stays 1 with the new byte.
//   - rx_ack with rx_valid=0 has no effect.
//   - rx_data holds its last value after ack.
//  err_clr:
//   - clears frame_err and overrun.
//   - If err_clr and a set event occur in the same cycle, the set wins.
//  Latency:
//   - rx_strobe fires L = 3 + (baud_div+1)*(9*OSR + OSR/2 + 1) clocks after the first low clk-sample of rx_in.
//   - baud_div=0, OSR=16 gives L=156.
//  Mid-frame reset: immediate abort to IDLE; partial byte lost; flags cleared.
// TESTING
//  1. baud_div=0, send 0xA5 with a good stop bit -> rx_strobe exactly 156 clocks after the start edge.
//     Then rx_data=0xA5, rx_valid=1, frame_err=0.
//  2. Two frames 0x11, 0x22 back-to-back, no rx_ack -> rx_data=0x11, overrun=1, rx_strobe pulsed twice.
//     Then err_clr -> overrun=0.
//  3. Frame 0x3C with stop bit=0, line held low 40 bit times, then high, then send 0x7E.
//     Required: frame_err=1, rx_valid stays 0 after the bad frame, FSM stays in WAIT_IDLE while the line is low.
//     0x7E is then received correctly.
//  4. A 0.25-bit low glitch on the idle line -> FSM returns to IDLE, no strobe, no flags.
//     A 1-clock glitch inside the majority window of a data bit is ignored; byte received correctly.
//  5. baud_div=5: send 0xC3 with the transmitter at a bit period +3% and -3% off nominal.
//     Required: 0xC3 received correctly in both cases.
//     rx_ack coinciding with completion of a second byte 0x5A -> rx_valid stays 1, rx_data=0x5A, overrun=0.
//  6. Assert reset during DATA bit 4 -> all outputs 0 immediately.
//     After release, a following frame 0x81 is received correctly.

Source files
------------

// File: rtl/risc8_uart_rx.sv
// risc8_uart_rx: 8N1 serial receiver with oversampling, 3-sample majority vote,
// a one-byte holding register, and sticky framing/overrun flags.
module risc8_uart_rx #(
  parameter int OSR = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] baud_div,
  input  logic       rx_in,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_strobe,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int SW = $clog2(OSR);
  localparam logic [SW-1:0] SUB_LO  = SW'(OSR/2 - 1);
  localparam logic [SW-1:0] SUB_MID = SW'(OSR/2);
  localparam logic [SW-1:0] SUB_HI  = SW'(OSR/2 + 1);
  localparam logic [SW-1:0] SUB_END = SW'(OSR - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state, state_nxt;

  logic          sync1, rxs, rxs_prev;
  logic [7:0]    pre;
  logic [SW-1:0] sub;
  logic [3:0]    bitcnt;
  logic          samp_a, samp_b;
  logic [7:0]    shreg;
  logic          shift_en, complete, ferr_set;

  // One prescaler tick marks one oversample slot; the bit is resolved mid-bit.
  logic tick, decide, wrap, start_edge, bit_val;
  assign tick       = (pre == 8'd0);
  assign decide     = tick && (sub == SUB_HI);
  assign wrap       = tick && (sub == SUB_END);
  assign start_edge = (state == IDLE) && rxs_prev && !rxs;
  assign bit_val    = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign busy       = (state != IDLE);

  // Two-flop synchroniser plus edge history; preset high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rx_in;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  // Prescaler, subsample counter, majority samples and shift register.
  // Clearing the prescaler to 0 makes the first tick land on the cycle after start detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre    <= '0;
      sub    <= '0;
      bitcnt <= '0;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
      shreg  <= '0;
    end else begin
      if (start_edge) begin
        pre    <= '0;
        sub    <= '0;
        bitcnt <= '0;
      end else begin
        pre <= tick ? baud_div : pre - 8'd1;
        if (tick) sub <= sub + SW'(1);
        if (shift_en) bitcnt <= bitcnt + 4'd1;
      end
      if (tick && sub == SUB_LO)  samp_a <= rxs;
      if (tick && sub == SUB_MID) samp_b <= rxs;
      if (shift_en) shreg <= {bit_val, shreg[7:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and datapath strobes.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    complete  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE:      if (start_edge) state_nxt = START;
      START: begin
        // A high start bit is a glitch; a real one lasts until the bit boundary.
        if (decide && bit_val) state_nxt = IDLE;
        else if (wrap)         state_nxt = DATA;
      end
      DATA: begin
        if (decide && bitcnt < 4'd8)  shift_en  = 1'b1;
        if (wrap && bitcnt == 4'd8)   state_nxt = STOP;
      end
      STOP: begin
        // Leaving at mid-bit leaves half a bit of slack for a back-to-back start edge.
        if (decide) begin
          if (bit_val) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: if (rxs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Holding register and sticky flags; a set event beats err_clr in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_strobe <= complete;
      if (err_clr) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (ferr_set) frame_err <= 1'b1;
      if (complete && (!rx_valid || rx_ack)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else begin
        if (complete) overrun  <= 1'b1;
        if (rx_ack)   rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_risc8_uart_rx.sv
// Bench for risc8_uart_rx: directed vector table, multi-cycle corner sequences,
// and randomized frames checked against a byte-level holding-register model.
module tb_risc8_uart_rx;

  logic       clk = 1'b0;
  logic       reset, rx_in, rx_ack, err_clr;
  logic [7:0] baud_div;
  logic [7:0] rx_data;
  logic       rx_valid, rx_strobe, frame_err, overrun, busy;

  risc8_uart_rx #(.OSR(16)) dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .rx_in(rx_in),
    .rx_ack(rx_ack), .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_strobe(rx_strobe), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  always @(negedge clk) if (rx_strobe) strobes++;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ack;
    logic       clr;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1; @(negedge clk); rx_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; idle(2); reset = 1'b1; idle(2);
  endtask

  // Start bit plus 8 data bits, LSB first; optional 1-clock glitch mid data bit gb.
  task automatic send_bits(input logic [7:0] d, input int p, input int gb);
    rx_in = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      if (i == gb) begin
        repeat (p/2) @(negedge clk);
        rx_in = ~d[i];
        @(negedge clk);
        rx_in = d[i];
        repeat (p - p/2 - 1) @(negedge clk);
      end else begin
        repeat (p) @(negedge clk);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int p, input int gb);
    send_bits(d, p, gb);
    rx_in = stop;
    repeat (p) @(negedge clk);
    rx_in = 1'b1;
  endtask

  int lat, s0, p, bd, m_strb;
  logic [7:0] d, m_data;
  logic stop, m_valid, m_ovr, m_ferr;

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h33, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h33, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h0F, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'hF0, 1'b1, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0};

    reset = 1'b0; rx_in = 1'b1; rx_ack = 1'b0; err_clr = 1'b0; baud_div = 8'd0;
    idle(3);
    chk("reset_data",   rx_data,   0);
    chk("reset_valid",  rx_valid,  0);
    chk("reset_strobe", rx_strobe, 0);
    chk("reset_ferr",   frame_err, 0);
    chk("reset_ovr",    overrun,   0);
    chk("reset_busy",   busy,      0);
    reset = 1'b1;
    idle(5);

    // Latency from first low sample to rx_strobe
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1, 16, -1);
      for (int n = 1; n <= 400; n++) begin
        @(negedge clk);
        if (rx_strobe && lat < 0) lat = n - 1;
      end
    join
    chk("t1_latency", lat, 156);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_valid", rx_valid, 1);
    chk("t1_ferr", frame_err, 0);

    // Directed vector table
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].ack) pulse_ack();
      if (vecs[i].clr) pulse_clr();
      send_frame(vecs[i].data, vecs[i].stop, 16, -1);
      idle(16);
      chk($sformatf("vec%0d_data", i),  rx_data,   vecs[i].exp_data);
      chk($sformatf("vec%0d_valid", i), rx_valid,  vecs[i].exp_valid);
      chk($sformatf("vec%0d_ovr", i),   overrun,   vecs[i].exp_ovr);
      chk($sformatf("vec%0d_ferr", i),  frame_err, vecs[i].exp_ferr);
    end

    // Back-to-back frames without ack -> overrun, then err_clr
    do_reset();
    s0 = strobes;
    send_frame(8'h11, 1'b1, 16, -1);
    send_frame(8'h22, 1'b1, 16, -1);
    idle(16);
    chk("t2_data", rx_data, 8'h11);
    chk("t2_ovr", overrun, 1);
    chk("t2_strobes", strobes - s0, 2);
    pulse_clr();
    chk("t2_ovr_clr", overrun, 0);

    // Bad stop bit, line held low 40 bit times
    do_reset();
    send_bits(8'h3C, 16, -1);
    rx_in = 1'b0;
    idle(16*20);
    chk("t3_ferr", frame_err, 1);
    chk("t3_valid", rx_valid, 0);
    chk("t3_busy_mid", busy, 1);
    idle(16*21);
    chk("t3_busy_end", busy, 1);
    rx_in = 1'b1;
    idle(20);
    chk("t3_idle", busy, 0);
    send_frame(8'h7E, 1'b1, 16, -1);
    idle(16);
    chk("t3_data", rx_data, 8'h7E);
    chk("t3_valid2", rx_valid, 1);

    // Quarter-bit idle glitch, then 1-clock glitch inside a data bit's vote window
    do_reset();
    s0 = strobes;
    rx_in = 1'b0; idle(4); rx_in = 1'b1;
    idle(40);
    chk("t4_busy", busy, 0);
    chk("t4_strobes", strobes - s0, 0);
    chk("t4_ferr", frame_err, 0);
    chk("t4_valid", rx_valid, 0);
    send_frame(8'h96, 1'b1, 16, 3);
    idle(16);
    chk("t4_data", rx_data, 8'h96);
    chk("t4_valid2", rx_valid, 1);

    // baud_div=5 with +-3% transmitter, then ack coinciding with completion
    do_reset();
    baud_div = 8'd5;
    send_frame(8'hC3, 1'b1, 99, -1);
    idle(100);
    chk("t5_slow_data", rx_data, 8'hC3);
    chk("t5_slow_ferr", frame_err, 0);
    pulse_ack();
    send_frame(8'hC3, 1'b1, 93, -1);
    idle(100);
    chk("t5_fast_data", rx_data, 8'hC3);
    chk("t5_fast_valid", rx_valid, 1);
    chk("t5_fast_ferr", frame_err, 0);
    fork
      send_frame(8'h5A, 1'b1, 96, -1);
      begin
        repeat (921) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        chk("t5_ack_strobe", rx_strobe, 1);
        rx_ack = 1'b0;
      end
    join
    idle(10);
    chk("t5_ack_valid", rx_valid, 1);
    chk("t5_ack_data", rx_data, 8'h5A);
    chk("t5_ack_ovr", overrun, 0);

    // Reset during data bit 4
    do_reset();
    baud_div = 8'd0;
    send_frame(8'h12, 1'b1, 16, -1);
    idle(16);
    fork
      send_frame(8'hFF, 1'b1, 16, -1);
      begin
        repeat (16*5 + 8) @(negedge clk);
        chk("t6_busy_pre", busy, 1);
        reset = 1'b0;
        #1;
        chk("t6_data", rx_data, 0);
        chk("t6_valid", rx_valid, 0);
        chk("t6_strobe", rx_strobe, 0);
        chk("t6_ferr", frame_err, 0);
        chk("t6_ovr", overrun, 0);
        chk("t6_busy", busy, 0);
      end
    join
    idle(4);
    reset = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, 16, -1);
    idle(16);
    chk("t6_after_data", rx_data, 8'h81);
    chk("t6_after_valid", rx_valid, 1);

    // Randomized frames against a holding-register model
    do_reset();
    m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0; m_ferr = 1'b0; m_strb = 0;
    s0 = strobes;
    for (int f = 0; f < 20; f++) begin
      bd = $urandom_range(0, 2);
      p = 16 * (bd + 1);
      baud_div = 8'(bd);
      if ($urandom_range(0, 2) == 0) begin
        pulse_ack();
        m_valid = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) begin
        pulse_clr();
        m_ovr = 1'b0; m_ferr = 1'b0;
      end
      d = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop, p, -1);
      idle(p);
      if (!stop) m_ferr = 1'b1;
      else begin
        m_strb++;
        if (!m_valid) begin m_data = d; m_valid = 1'b1; end
        else m_ovr = 1'b1;
      end
      chk($sformatf("rnd%0d_data", f),    rx_data,   m_data);
      chk($sformatf("rnd%0d_valid", f),   rx_valid,  m_valid);
      chk($sformatf("rnd%0d_ovr", f),     overrun,   m_ovr);
      chk($sformatf("rnd%0d_ferr", f),    frame_err, m_ferr);
      chk($sformatf("rnd%0d_strobes", f), strobes - s0, m_strb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
